// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32I fetch and decode stages.
package fetch_pkg;
  localparam int          XLEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {RUN, FAULT} fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } if_id_t;
endpackage

// File: rtl/if_id_reg.sv
// Single-slot valid/ready pipeline register with flush; payload width is generic.
module if_id_reg
  import fetch_pkg::*;
#(
  parameter int           W       = 64,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         load,
  input  logic         ready,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);
  // Caller asserts load only when the slot is empty or being consumed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      q     <= RST_VAL;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end
endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction fetch: PC register, range check, fault FSM and IF/ID slot.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_data_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        id_ready_i,
  output logic        id_valid_o,
  output logic [31:0] id_instr_o,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_pc4_o,
  output logic        fault_o
);
  localparam logic [31:0] PC_RST   = RESET_PC & ~32'h3;
  // 33-bit limit so a full 4 GiB memory does not wrap to zero.
  localparam logic [32:0] PC_LIMIT = 33'(IMEM_WORDS) << 2;
  localparam if_id_t      SLOT_RST = '{instr: NOP_INSTR, pc: 32'h0};

  fetch_state_t state;
  logic [31:0]  pc;
  logic         load_ok, in_range, slot_ld;
  if_id_t       slot_d, slot_q;

  assign load_ok  = !id_valid_o || id_ready_i;
  assign in_range = {1'b0, pc} < PC_LIMIT;
  assign slot_ld  = (state == RUN) && !redirect_i && load_ok && in_range;
  assign slot_d   = '{instr: imem_data_i, pc: pc};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= RUN;
      pc      <= PC_RST;
      fault_o <= 1'b0;
    end else if (redirect_i) begin
      pc <= {redirect_pc_i[31:2], 2'b00};
      if (redirect_pc_i[1:0] != 2'b00) begin
        state   <= FAULT;
        fault_o <= 1'b1;
      end else begin
        state   <= RUN;
        fault_o <= 1'b0;
      end
    end else if (state == RUN && load_ok) begin
      if (in_range) begin
        pc <= pc + 32'd4;
      end else begin
        state   <= FAULT;
        fault_o <= 1'b1;
      end
    end
  end

  // Slot drains on ready whenever nothing new is loaded, including in FAULT.
  if_id_reg #(.W($bits(if_id_t)), .RST_VAL(SLOT_RST)) u_if_id (
    .clk   (clk),
    .reset (reset),
    .flush (redirect_i),
    .load  (slot_ld),
    .ready (id_ready_i),
    .d     (slot_d),
    .valid (id_valid_o),
    .q     (slot_q)
  );

  assign imem_addr_o = {pc[31:2], 2'b00};
  assign id_instr_o  = slot_q.instr;
  assign id_pc_o     = slot_q.pc;
  assign id_pc4_o    = slot_q.pc + 32'd4;
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a 256-word combinational instruction memory.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr, imem_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_ready, id_valid, fault;
  logic [31:0] id_instr, id_pc, id_pc4;
  logic [31:0] mem [0:255];
  int          n_cmp = 0;
  int          n_err = 0;

  fetch_stage #(.RESET_PC(32'h0), .IMEM_WORDS(256)) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_addr_o   (imem_addr),
    .imem_data_i   (imem_data),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .id_ready_i    (id_ready),
    .id_valid_o    (id_valid),
    .id_instr_o    (id_instr),
    .id_pc_o       (id_pc),
    .id_pc4_o      (id_pc4),
    .fault_o       (fault)
  );

  always #5 clk = ~clk;

  assign imem_data = (imem_addr < 32'h400) ? mem[imem_addr[9:2]] : 32'hDEAD_BEEF;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic slot(input string tag, input logic [31:0] pc, input logic [31:0] nxt);
    chk({tag, " valid"}, {31'h0, id_valid}, 32'h1);
    chk({tag, " pc"}, id_pc, pc);
    chk({tag, " instr"}, id_instr, mem[pc[9:2]]);
    chk({tag, " addr"}, imem_addr, nxt);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 | (i << 2);
    mem[0] = 32'h0050_0093;
    mem[1] = 32'h00A0_0113;
    reset = 1'b1; redirect = 1'b0; redirect_pc = '0; id_ready = 1'b1;
    tick(); tick();
    chk("rst valid", {31'h0, id_valid}, 32'h0);
    chk("rst instr", id_instr, 32'h0000_0013);
    chk("rst pc", id_pc, 32'h0);
    chk("rst fault", {31'h0, fault}, 32'h0);
    chk("rst addr", imem_addr, 32'h0);
    reset = 1'b0;

    tick();
    chk("c1 instr", id_instr, 32'h0050_0093);
    chk("c1 pc", id_pc, 32'h0);
    chk("c1 valid", {31'h0, id_valid}, 32'h1);
    tick();
    chk("c2 instr", id_instr, 32'h00A0_0113);
    chk("c2 pc", id_pc, 32'h4);
    chk("c2 pc4", id_pc4, 32'h8);
    tick();
    slot("c3", 32'h8, 32'hC);

    // stall three cycles on slot 0x8
    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      slot("stall", 32'h8, 32'hC);
    end
    id_ready = 1'b1;
    tick();
    slot("release", 32'hC, 32'h10);

    // redirect during a stall flushes the held slot
    id_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h40;
    tick();
    chk("redir valid", {31'h0, id_valid}, 32'h0);
    chk("redir addr", imem_addr, 32'h40);
    redirect = 1'b0; id_ready = 1'b1;
    tick();
    slot("redir tgt", 32'h40, 32'h44);

    // run off the end of memory
    redirect = 1'b1; redirect_pc = 32'h3F8;
    tick();
    redirect = 1'b0;
    tick();
    slot("end-1", 32'h3F8, 32'h3FC);
    tick();
    slot("end", 32'h3FC, 32'h400);
    chk("end fault", {31'h0, fault}, 32'h0);
    tick();
    chk("oor fault", {31'h0, fault}, 32'h1);
    chk("oor valid", {31'h0, id_valid}, 32'h0);
    chk("oor addr", imem_addr, 32'h400);
    tick();
    chk("oor hold fault", {31'h0, fault}, 32'h1);
    chk("oor hold addr", imem_addr, 32'h400);
    chk("oor hold valid", {31'h0, id_valid}, 32'h0);
    redirect = 1'b1; redirect_pc = 32'h0;
    tick();
    chk("clr fault", {31'h0, fault}, 32'h0);
    chk("clr addr", imem_addr, 32'h0);
    redirect = 1'b0;
    tick();
    slot("clr slot", 32'h0, 32'h4);

    // misaligned redirect
    redirect = 1'b1; redirect_pc = 32'h42;
    tick();
    chk("mis fault", {31'h0, fault}, 32'h1);
    chk("mis addr", imem_addr, 32'h40);
    chk("mis valid", {31'h0, id_valid}, 32'h0);
    redirect = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("mis hold valid", {31'h0, id_valid}, 32'h0);
      chk("mis hold addr", imem_addr, 32'h40);
      chk("mis hold fault", {31'h0, fault}, 32'h1);
    end

    // asynchronous reset between edges while in FAULT
    #2 reset = 1'b1;
    #1;
    chk("arst fault", {31'h0, fault}, 32'h0);
    chk("arst instr", id_instr, 32'h0000_0013);
    chk("arst pc", id_pc, 32'h0);
    chk("arst addr", imem_addr, 32'h0);
    chk("arst valid", {31'h0, id_valid}, 32'h0);
    reset = 1'b0;
    tick();
    slot("resume", 32'h0, 32'h4);
    chk("resume instr", id_instr, 32'h0050_0093);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
